pmc_ac_config_master: RTL and testbench

//  Bus initiator that loads the PMC analog-configuration registers (REG_0..REG_3) over the

---
 rtl/pmc_ac_pkg.sv | 30 +++
 rtl/pmc_ac_config_master_if.sv | 16 +
 rtl/pmc_ac_wait_timer.sv | 25 ++
 rtl/pmc_ac_config_master.sv | 139 +++++++++++++
 tb/tb_pmc_ac_config_master.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pmc_ac_pkg.sv
// Shared types and constants for the PMC analog-configuration bus master:
// register offset table, FSM state encoding and error codes.
package pmc_ac_pkg;

    localparam int PMC_AC_NUM_REGS = 4;

    localparam logic [7:0] REG_OFFSET [4] = '{8'h00, 8'h04, 8'h08, 8'h0C};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RSP,
        ST_RD_REQ,
        ST_RD_RSP,
        ST_FINISH,
        ST_ERROR
    } pmc_ac_master_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_TIMEOUT  = 2'd1,
        ERR_MISMATCH = 2'd2,
        ERR_ABORTED  = 2'd3
    } pmc_ac_err_t;

    function automatic logic [31:0] reg_addr(input logic [1:0] idx);
        return {24'h0, REG_OFFSET[idx]};
    endfunction

endpackage

// File: rtl/pmc_ac_config_master_if.sv
// Data-bus req/gnt/rvalid channel between the config master and the analog-conf slave.
interface pmc_ac_config_master_if;

    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/pmc_ac_wait_timer.sv
// 4-bit wait counter shared by grant and response waits; at_limit flags the last
// permitted waiting cycle so the caller can raise a timeout on it.
module pmc_ac_wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic at_limit
);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign at_limit = (cnt == 4'(LIMIT - 1));

endmodule

// File: rtl/pmc_ac_config_master.sv
// Loads REG_0..REG_(NUM_REGS-1) over the req/gnt/rvalid bus, optionally verifying each
// by read-back, and reports done or a sticky error with code and register index.
module pmc_ac_config_master
    import pmc_ac_pkg::*;
#(
    parameter int NUM_REGS    = PMC_AC_NUM_REGS,
    parameter bit VERIFY      = 1'b1,
    parameter int GNT_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [32*NUM_REGS-1:0]   conf_data,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [1:0]               err_code,
    output logic [1:0]               err_idx,
    pmc_ac_config_master_if.master   bus
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_REGS - 1);

    pmc_ac_master_state_t state_q, state_d;
    logic [1:0]              index_q, index_d;
    logic [32*NUM_REGS-1:0]  shadow_q;
    logic                    error_q;
    pmc_ac_err_t             err_q, fail_d;
    logic [1:0]              err_idx_q;
    logic                    abort_pend_q;
    logic                    abort_now;
    logic                    tmr_en;
    logic                    tmr_at_limit;
    logic [31:0]             cur_data;

    assign cur_data  = shadow_q[32*index_q +: 32];
    // An abort seen during a granted transaction is held until its response arrives.
    assign abort_now = abort || abort_pend_q;

    pmc_ac_wait_timer #(.LIMIT(GNT_TIMEOUT)) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (!tmr_en),
        .en       (tmr_en),
        .at_limit (tmr_at_limit)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        fail_d  = ERR_NONE;
        tmr_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WR_REQ;
                    index_d = '0;
                end
            end
            ST_WR_REQ, ST_RD_REQ: begin
                if (bus.gnt) begin
                    state_d = (state_q == ST_WR_REQ) ? ST_WR_RSP : ST_RD_RSP;
                end else if (abort_now) begin
                    fail_d = ERR_ABORTED;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_at_limit) fail_d = ERR_TIMEOUT;
                end
            end
            ST_WR_RSP, ST_RD_RSP: begin
                if (bus.rvalid) begin
                    if (state_q == ST_RD_RSP && bus.rdata != cur_data) begin
                        fail_d = ERR_MISMATCH;
                    end else if (abort_now) begin
                        fail_d = ERR_ABORTED;
                    end else if (state_q == ST_WR_RSP && VERIFY) begin
                        state_d = ST_RD_REQ;
                    end else if (index_q == LAST_IDX) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_WR_REQ;
                        index_d = index_q + 2'd1;
                    end
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_at_limit) fail_d = ERR_TIMEOUT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (fail_d != ERR_NONE) state_d = ST_ERROR;
    end

    // NOTE: the shadow images are cleared on reset so a stale image is never compared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            index_q      <= '0;
            shadow_q     <= '0;
            error_q      <= 1'b0;
            err_q        <= ERR_NONE;
            err_idx_q    <= '0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            if (state_q == ST_IDLE && start) begin
                shadow_q  <= conf_data;
                error_q   <= 1'b0;
                err_q     <= ERR_NONE;
                err_idx_q <= '0;
            end else if (fail_d != ERR_NONE) begin
                error_q   <= 1'b1;
                err_q     <= fail_d;
                err_idx_q <= index_q;
            end
            if (state_q == ST_IDLE || state_q == ST_FINISH || state_q == ST_ERROR) begin
                abort_pend_q <= 1'b0;
            end else if (abort) begin
                abort_pend_q <= 1'b1;
            end
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_FINISH);
    assign error    = error_q;
    assign err_code = err_q;
    assign err_idx  = err_idx_q;

    assign bus.req   = (state_q == ST_WR_REQ) || (state_q == ST_RD_REQ);
    assign bus.we    = (state_q == ST_WR_REQ);
    assign bus.be    = bus.req ? 4'hF : 4'h0;
    assign bus.addr  = bus.req ? reg_addr(index_q) : 32'h0;
    assign bus.wdata = (state_q == ST_WR_REQ) ? cur_data : 32'h0;

endmodule

// File: tb/tb_pmc_ac_config_master.sv
// Self-checking bench: behavioural slave with transaction log, expected bus traffic
// derived from the register images, directed error scenarios plus randomized runs.
module tb_pmc_ac_config_master;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [127:0] conf_data = '0;
    logic         busy, done, error;
    logic [1:0]   err_code, err_idx;

    int checks = 0;
    int errors = 0;

    pmc_ac_config_master_if bus ();

    pmc_ac_config_master #(.NUM_REGS(4), .VERIFY(1'b1), .GNT_TIMEOUT(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .conf_data (conf_data),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_code  (err_code),
        .err_idx   (err_idx),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Slave configuration, written only by the main sequence.
    bit          rand_stall = 1'b0;
    bit          hold_en = 1'b0;
    logic [31:0] hold_addr = '0;
    bit          corrupt_en = 1'b0;
    logic [31:0] corrupt_addr = '0;
    logic        gnt_ok;

    // Slave state and observations.
    logic [31:0] mem [4];
    logic [40:0] log_q [$];
    int          stall_total = 0;
    int          stall_moved = 0;
    logic        stall_prev = 1'b0;
    logic [64:0] stall_sig = '0;

    assign bus.gnt = bus.req && gnt_ok && !(hold_en && bus.addr == hold_addr);

    always @(posedge clk) begin
        bus.rvalid <= bus.req && bus.gnt;
        bus.rdata  <= '0;
        if (bus.req && bus.gnt) begin
            log_q.push_back({bus.we, bus.addr[7:0], bus.we ? bus.wdata : 32'h0});
            if (bus.we) mem[bus.addr[3:2]] <= bus.wdata;
            else if (corrupt_en && bus.addr == corrupt_addr) bus.rdata <= 32'h3333_0000;
            else bus.rdata <= mem[bus.addr[3:2]];
        end
        if (bus.req && !bus.gnt) begin
            stall_total <= stall_total + 1;
            if (stall_prev && {bus.we, bus.addr, bus.wdata} != stall_sig) stall_moved <= stall_moved + 1;
        end
        stall_prev <= bus.req && !bus.gnt;
        stall_sig  <= {bus.we, bus.addr, bus.wdata};
    end

    // Random grant stalls, capped well below the timeout.
    initial begin
        int consec = 0;
        gnt_ok = 1'b1;
        forever begin
            @(negedge clk);
            if (rand_stall && consec < 4 && $urandom_range(0, 2) == 0) begin
                gnt_ok = 1'b0;
                consec++;
            end else begin
                gnt_ok = 1'b1;
                consec = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: each register is written with its image, then read back, in offset order.
    logic [40:0] exp_q [$];
    function automatic void build_model(input logic [127:0] data, input int n_regs);
        exp_q.delete();
        for (int i = 0; i < n_regs; i++) begin
            exp_q.push_back({1'b1, 8'(4 * i), data[32*i +: 32]});
            exp_q.push_back({1'b0, 8'(4 * i), 32'h0});
        end
    endfunction

    task automatic compare_log(input string tag, input int base);
        check({tag, "_len"}, 64'(log_q.size() - base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++)
            check($sformatf("%s_txn%0d", tag, i), 64'(log_q[base + i]), 64'(exp_q[i]));
    endtask

    // Runs one sequence; cycle k is the k-th cycle after the edge that samples start.
    // mode 4: abort with REG_1 write grant; 5: restart attempt mid-run; 6: reset in RD_RSP.
    int err_at_start;
    task automatic run_seq(input logic [127:0] data, input int mode,
                           output int done_cyc, output int done_cnt, output int end_cyc);
        done_cyc = 0;
        done_cnt = 0;
        end_cyc  = 0;
        @(negedge clk);
        conf_data = data;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        err_at_start = int'(error);
        for (int k = 1; k <= 600; k++) begin
            if (done) begin
                done_cnt++;
                done_cyc = k;
            end
            if (!busy) begin
                end_cyc = k;
                break;
            end
            if (mode == 4 && bus.req && bus.we && bus.addr == 32'h4) abort = 1'b1;
            if (mode == 5 && k == 5) begin
                start = 1'b1;
                conf_data = ~data;
            end
            if (mode == 6 && k == 8) rst_n = 1'b0;
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
            if (mode == 6 && k == 8) begin
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_flags", 64'({done, error, err_code, err_idx}), 64'd0);
                check("rst_bus", 64'({bus.req, bus.we, bus.be, bus.addr}), 64'd0);
                check("rst_wdata", 64'(bus.wdata), 64'd0);
                rst_n = 1'b1;
                end_cyc = k;
                break;
            end
        end
        check("run_bounded", 64'(end_cyc != 0), 64'd1);
    endtask

    initial begin
        logic [127:0] data;
        int dc, dn, ec, base, moved0, stall0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'({busy, done, error, err_code, err_idx}), 64'd0);
        check("reset_bus", 64'({bus.req, bus.we, bus.be, bus.addr}), 64'd0);
        check("reset_wdata", 64'(bus.wdata), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 64'({busy, bus.req}), 64'd0);

        // 1: zero-wait slave, fixed images
        data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        build_model(data, 4);
        base = log_q.size();
        run_seq(data, 0, dc, dn, ec);
        compare_log("t1", base);
        check("t1_done_cycle", 64'(dc), 64'd17);
        check("t1_done_once", 64'(dn), 64'd1);
        check("t1_busy_drop", 64'(ec), 64'd18);
        check("t1_error", 64'({error, err_code}), 64'd0);
        check("t1_mem2", 64'(mem[2]), 64'h3333_3333);

        // Randomized images and grant stalls
        rand_stall = 1'b1;
        for (int r = 0; r < 6; r++) begin
            data = {$urandom, $urandom, $urandom, $urandom};
            build_model(data, 4);
            base = log_q.size();
            moved0 = stall_moved;
            run_seq(data, 0, dc, dn, ec);
            compare_log($sformatf("rnd%0d", r), base);
            check($sformatf("rnd%0d_done", r), 64'(dn), 64'd1);
            check($sformatf("rnd%0d_error", r), 64'({error, err_code}), 64'd0);
            check($sformatf("rnd%0d_stable", r), 64'(stall_moved - moved0), 64'd0);
        end
        rand_stall = 1'b0;
        repeat (3) @(negedge clk);

        // 2: grant withheld on REG_2
        data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        hold_en = 1'b1;
        hold_addr = 32'h8;
        build_model(data, 2);
        base = log_q.size();
        moved0 = stall_moved;
        stall0 = stall_total;
        run_seq(data, 0, dc, dn, ec);
        hold_en = 1'b0;
        compare_log("t2", base);
        check("t2_req_cycles", 64'(stall_total - stall0), 64'd15);
        check("t2_stable", 64'(stall_moved - moved0), 64'd0);
        check("t2_err", 64'({error, err_code, err_idx}), 64'({1'b1, 2'd1, 2'd2}));
        check("t2_no_done", 64'(dn), 64'd0);

        // 3: read-back mismatch on REG_2
        corrupt_en = 1'b1;
        corrupt_addr = 32'h8;
        build_model(data, 3);
        base = log_q.size();
        run_seq(data, 0, dc, dn, ec);
        corrupt_en = 1'b0;
        check("t3_err_cleared_on_start", 64'(err_at_start), 64'd0);
        compare_log("t3", base);
        check("t3_err", 64'({error, err_code, err_idx}), 64'({1'b1, 2'd2, 2'd2}));
        check("t3_busy_drop", 64'({busy, dn}), 64'd0);

        // 4: abort in the same cycle as the REG_1 write grant
        build_model(data, 2);
        void'(exp_q.pop_back());
        base = log_q.size();
        run_seq(data, 4, dc, dn, ec);
        compare_log("t4", base);
        check("t4_err", 64'({error, err_code, err_idx}), 64'({1'b1, 2'd3, 2'd1}));
        check("t4_no_done", 64'(dn), 64'd0);

        // 5: abort while idle, then start pulsed and images changed mid-run
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        data = {$urandom, $urandom, $urandom, $urandom};
        build_model(data, 4);
        base = log_q.size();
        run_seq(data, 5, dc, dn, ec);
        compare_log("t5", base);
        check("t5_done_cycle", 64'(dc), 64'd17);
        check("t5_error", 64'({error, err_code}), 64'd0);

        // 6: reset during the REG_1 read response, then a fresh full run
        build_model(data, 2);
        base = log_q.size();
        run_seq(data, 6, dc, dn, ec);
        compare_log("t6_partial", base);
        @(negedge clk);
        data = {$urandom, $urandom, $urandom, $urandom};
        build_model(data, 4);
        base = log_q.size();
        run_seq(data, 0, dc, dn, ec);
        compare_log("t6_fresh", base);
        check("t6_done_cycle", 64'(dc), 64'd17);
        check("t6_error", 64'({error, err_code}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
